// File: rtl/div_req_arbiter_if.sv
// Bus bundle for div_req_arbiter: two requesters, the shared divider command/result
// path and the response channel. The arbiter sits on the slave side.
interface div_req_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_dividend;
  logic [WIDTH-1:0] req0_divisor;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_dividend;
  logic [WIDTH-1:0] req1_divisor;

  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic [1:0]       rsp_err;

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  div_done, div_quotient, div_remainder,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output div_start, div_dividend, div_divisor,
    output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err
  );

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output div_done, div_quotient, div_remainder,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  div_start, div_dividend, div_divisor,
    input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err
  );
endinterface

// File: rtl/div_req_arbiter.sv
// Round-robin arbiter sharing one divider between two requesters; one transaction in
// flight, divide-by-zero short-circuit and a WAIT-state timeout abort.
//
// state | meaning
// IDLE  | ready offered to the granted requester, operands captured on accept
// ISSUE | one-cycle div_start pulse with captured operands on the divider bus
// WAIT  | counting cycles until div_done or timeout
// RESP  | response held stable until rsp_ready
module div_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input logic               clk,
  input logic               rst_n,
  div_req_arbiter_if.slave  bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic             r_div_start;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_quotient;
  logic [WIDTH-1:0] r_rsp_remainder;
  logic [1:0]       r_rsp_err;

  logic             w_grant;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_accept;
  logic             w_busy;
  logic [WIDTH-1:0] w_sel_dividend;
  logic [WIDTH-1:0] w_sel_divisor;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) w_grant = ~r_last_grant;
    else if (bus.req1_valid)              w_grant = 1'b1;
  end

  // Gated by rst_n so ready is also low while reset is asserted.
  assign w_ready0       = rst_n && (r_state == IDLE) && bus.req0_valid && !w_grant;
  assign w_ready1       = rst_n && (r_state == IDLE) && bus.req1_valid &&  w_grant;
  assign w_accept       = w_ready0 || w_ready1;
  assign w_sel_dividend = w_grant ? bus.req1_dividend : bus.req0_dividend;
  assign w_sel_divisor  = w_grant ? bus.req1_divisor  : bus.req0_divisor;
  assign w_busy         = (r_state == ISSUE) || (r_state == WAIT);

  assign bus.req0_ready    = w_ready0;
  assign bus.req1_ready    = w_ready1;
  assign bus.div_start     = r_div_start;
  assign bus.div_dividend  = w_busy ? r_dividend : '0;
  assign bus.div_divisor   = w_busy ? r_divisor  : '0;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_quotient  = r_rsp_quotient;
  assign bus.rsp_remainder = r_rsp_remainder;
  assign bus.rsp_err       = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_last_grant    <= 1'b1;
      r_id            <= 1'b0;
      r_dividend      <= '0;
      r_divisor       <= '0;
      r_cnt           <= '0;
      r_div_start     <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_id        <= 1'b0;
      r_rsp_quotient  <= '0;
      r_rsp_remainder <= '0;
      r_rsp_err       <= 2'b00;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id       <= w_grant;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            if (w_sel_divisor == '0) begin
              r_state         <= RESP;
              r_rsp_valid     <= 1'b1;
              r_rsp_id        <= w_grant;
              r_rsp_quotient  <= '1;
              r_rsp_remainder <= w_sel_dividend;
              r_rsp_err       <= 2'b01;
            end else begin
              r_state     <= ISSUE;
              r_div_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: begin
          // A result arriving on the timeout cycle still counts as a normal completion.
          if (bus.div_done) begin
            r_state         <= RESP;
            r_rsp_valid     <= 1'b1;
            r_rsp_id        <= r_id;
            r_rsp_quotient  <= bus.div_quotient;
            r_rsp_remainder <= bus.div_remainder;
            r_rsp_err       <= 2'b00;
            r_cnt           <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state         <= RESP;
            r_rsp_valid     <= 1'b1;
            r_rsp_id        <= r_id;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_err       <= 2'b10;
            r_cnt           <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state         <= IDLE;
            r_last_grant    <= r_rsp_id;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= 1'b0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_err       <= 2'b00;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_req_arbiter.sv
// Randomized and directed bench for div_req_arbiter against a transaction-level model
// of grant order, result values and response latency.
module tb_div_req_arbiter;
  localparam int W  = 32;
  localparam int TO = 40;

  logic clk;
  logic rst_n;

  div_req_arbiter_if #(.WIDTH(W)) bus ();

  div_req_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_last;
  int n_start = 0;

  // Divider stand-in: done pulses d_lat cycles after the start cycle; d_lat == 0 never answers.
  int         d_lat = 1;
  int         d_cnt = 0;
  logic       d_done = 1'b0;
  logic       f_done = 1'b0;
  logic [W-1:0] d_q = '0;
  logic [W-1:0] d_r = '0;

  assign bus.div_done      = d_done | f_done;
  assign bus.div_quotient  = d_q;
  assign bus.div_remainder = d_r;

  always @(posedge clk) begin
    d_done <= 1'b0;
    if (bus.div_start) begin
      n_start++;
      if (bus.div_divisor != '0) begin
        d_q <= bus.div_dividend / bus.div_divisor;
        d_r <= bus.div_dividend % bus.div_divisor;
      end
      if (d_lat == 1) d_done <= 1'b1;
      d_cnt <= (d_lat > 1) ? d_lat - 1 : 0;
    end else if (d_cnt > 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) d_done <= 1'b1;
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "_start"}, bus.div_start, 0);
    chk_eq({tag, "_ddvd"}, bus.div_dividend, 0);
    chk_eq({tag, "_ddvs"}, bus.div_divisor, 0);
    chk_eq({tag, "_rv"}, bus.rsp_valid, 0);
    chk_eq({tag, "_rid"}, bus.rsp_id, 0);
    chk_eq({tag, "_rq"}, bus.rsp_quotient, 0);
    chk_eq({tag, "_rr"}, bus.rsp_remainder, 0);
    chk_eq({tag, "_rerr"}, bus.rsp_err, 0);
    chk_eq({tag, "_rdy0"}, bus.req0_ready, 0);
    chk_eq({tag, "_rdy1"}, bus.req1_ready, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic serve(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int lat, input int hold);
    int g, exp_lat, waited, starts0;
    logic [W-1:0] a, b, eq, er;
    logic [1:0] ee;
    g = (v0 && v1) ? (m_last == 1 ? 0 : 1) : (v1 ? 1 : 0);
    a = g ? a1 : a0;
    b = g ? b1 : b0;
    if (b == 0) begin
      eq = '1; er = a; ee = 2'b01; exp_lat = 1;
    end else if (lat == 0 || lat > TO) begin
      eq = '0; er = '0; ee = 2'b10; exp_lat = TO + 2;
    end else begin
      eq = a / b; er = a % b; ee = 2'b00; exp_lat = lat + 2;
    end
    d_lat = lat;
    starts0 = n_start;
    bus.req0_valid = v0; bus.req0_dividend = a0; bus.req0_divisor = b0;
    bus.req1_valid = v1; bus.req1_dividend = a1; bus.req1_divisor = b1;
    #1;
    chk_eq("grant_rdy0", bus.req0_ready, g == 0);
    chk_eq("grant_rdy1", bus.req1_ready, g == 1);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_dividend = $urandom; bus.req1_dividend = $urandom;
    bus.req0_divisor = $urandom; bus.req1_divisor = $urandom;
    chk_eq("issue_start", bus.div_start, b != 0);
    chk_eq("issue_dvd", bus.div_dividend, (b != 0) ? a : '0);
    chk_eq("issue_dvs", bus.div_divisor, b);
    waited = 1;
    while (!bus.rsp_valid && waited < 80) begin
      @(negedge clk);
      waited++;
    end
    chk_eq("rsp_latency", waited, exp_lat);
    chk_eq("rsp_id", bus.rsp_id, g);
    chk_eq("rsp_q", bus.rsp_quotient, eq);
    chk_eq("rsp_r", bus.rsp_remainder, er);
    chk_eq("rsp_err", bus.rsp_err, ee);
    chk_eq("start_count", n_start - starts0, b != 0);
    chk_eq("resp_ddvd", bus.div_dividend, 0);
    for (int i = 0; i < hold; i++) begin
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      @(negedge clk);
      chk_eq("hold_rv", bus.rsp_valid, 1);
      chk_eq("hold_q", bus.rsp_quotient, eq);
      chk_eq("hold_r", bus.rsp_remainder, er);
      chk_eq("hold_id", bus.rsp_id, g);
      chk_eq("hold_err", bus.rsp_err, ee);
      chk_eq("hold_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk_eq("post_rv", bus.rsp_valid, 0);
    m_last = g;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hold, sel;
    bit v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_dividend = '0; bus.req0_divisor = '0;
    bus.req1_valid = 1'b0; bus.req1_dividend = '0; bus.req1_divisor = '0;
    bus.rsp_ready = 1'b0;
    m_last = 1;
    #3;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    serve(1, 61, 2, 0, 0, 0, 32, 0);
    serve(1, 100, 3, 1, 200, 7, 5, 0);
    serve(1, 100, 3, 1, 200, 7, 5, 0);
    serve(1, 100, 3, 1, 200, 7, 5, 0);
    serve(0, 0, 0, 1, 61, 0, 5, 0);
    serve(1, 500, 9, 0, 0, 0, 0, 2);

    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    chk_eq("stale_idle_rv", bus.rsp_valid, 0);
    chk_eq("stale_idle_start", bus.div_start, 0);
    @(negedge clk);
    chk_eq("stale_idle_rv2", bus.rsp_valid, 0);

    serve(1, 1000, 7, 0, 0, 0, 43, 5);
    serve(0, 0, 0, 1, 999, 10, TO, 0);
    serve(1, 77, 5, 1, 88, 3, 4, 10);

    d_lat = 20;
    bus.req0_valid = 1'b1; bus.req0_dividend = 100; bus.req0_divisor = 7;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.req0_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    m_last = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk_eq("midrst_norsp", bus.rsp_valid, 0);
    end
    serve(1, 100, 7, 1, 50, 6, 10, 1);

    for (int it = 0; it < 24; it++) begin
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      if (!v0 && !v1) v0 = 1'b1;
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1000));
      b1 = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      sel = $urandom_range(0, 9);
      lat = (sel == 0) ? 0 : (sel == 1) ? TO : $urandom_range(1, TO - 1);
      hold = $urandom_range(0, 3);
      serve(v0, a0, b0, v1, a1, b1, lat, hold);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/div_req_arbiter.md
DIV_REQ_ARBITER -- requirements
Module: div_req_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: TIMEOUT, 40, max cycles in WAIT before abort.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports: req0_valid input 1, req0_ready output 1, req0_dividend input WIDTH, req0_divisor input WIDTH -- requester 0.
REQ-006 Ports: req1_valid input 1, req1_ready output 1, req1_dividend input WIDTH, req1_divisor input WIDTH -- requester 1.
REQ-007 Ports: div_start output 1, div_dividend output WIDTH, div_divisor output WIDTH -- command to the shared non-restoring divider.
REQ-008 Ports: div_done input 1, div_quotient input WIDTH, div_remainder input WIDTH -- divider result, valid when div_done=1.
REQ-009 Ports: rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (requester index), rsp_quotient output WIDTH, rsp_remainder output WIDTH, rsp_err output 2 (bit0 divide-by-zero, bit1 timeout).

Function
REQ-010 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-011 IDLE: reqN_ready SHALL be high combinationally only for the granted requester; ready SHALL be low in all other states.
REQ-012 Grant: single valid requester SHALL win; both valid SHALL grant the requester not served last (round-robin via last_grant register).
REQ-013 On accept (valid & ready), operands and id SHALL be captured into registers; requester inputs SHALL not be used afterwards.
REQ-014 Accepted divisor == 0: SHALL go directly to RESP with quotient all-ones, remainder = dividend, rsp_err=2'b01; divider SHALL not be started.
REQ-015 Otherwise IDLE -> ISSUE; ISSUE SHALL assert div_start for exactly one cycle, then -> WAIT.
REQ-016 div_dividend/div_divisor SHALL equal the captured operands during ISSUE and WAIT, and be 0 otherwise.
REQ-017 WAIT: cycle counter SHALL start at 0 on entry and increment each cycle; div_done=1 SHALL latch div_quotient/div_remainder, rsp_err=0, -> RESP.
REQ-018 WAIT: counter reaching TIMEOUT-1 without div_done SHALL set quotient=0, remainder=0, rsp_err=2'b10, -> RESP; div_done on that same cycle SHALL take priority (normal result).
REQ-019 div_done outside WAIT SHALL be ignored.
REQ-020 RESP: rsp_valid high; rsp_id/quotient/remainder/err SHALL be stable until rsp_ready; on handshake SHALL update last_grant to rsp_id and -> IDLE.
REQ-021 Latency: accept at cycle T -> div_start at T+1; div_done sampled at cycle D -> rsp_valid at D+1; divide-by-zero accept at T -> rsp_valid at T+1.
REQ-022 Next accept SHALL occur no earlier than the cycle after the response handshake.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, all outputs 0, counter 0, captured registers 0, last_grant=1 (requester 0 wins first tie).
REQ-024 Reset mid-transaction SHALL abandon it with no response; a later stale div_done SHALL be ignored.

Verification
REQ-025 req0 61/2, divider model returns 30/1 after 32 cycles -> one div_start pulse with 61/2 on bus, rsp id=0 q=30 r=1 err=00.
REQ-026 req0 and req1 valid same cycle after reset -> req0 served first, req1 next; third tie -> req0.
REQ-027 req1 dividend 61 divisor 0 -> no div_start, rsp id=1 q=32'hFFFFFFFF r=61 err=01 one cycle after accept.
REQ-028 Divider never asserts done -> rsp after 40 WAIT cycles with q=0 r=0 err=10; late div_done ignored.
REQ-029 rsp_ready held low 10 cycles -> rsp outputs stable, both req_ready low, accept only after handshake.
REQ-030 rst_n low during WAIT -> all outputs 0 immediately, no rsp, subsequent div_done ignored, next request served normally.
